// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared period counter, per-channel duty compare, shadowed
// period/duty applied only at period boundaries. Define PWM_CENTER_EN for up/down counting.
module pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  logic [WIDTH-1:0] duty_nx,
    input  logic [WIDTH-1:0] cnt,
    output logic             out
);
    logic [WIDTH-1:0] duty_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh <= '0;
            out     <= 1'b0;
        end else begin
            if (upd) duty_sh <= duty_nx;
            out <= (cnt < duty_sh);
        end
    end
endmodule

module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic [CHANNELS-1:0]       out,
    output logic                      cycle_start,
    output logic                      upd_ack,
    output logic                      busy
);
    typedef struct packed {
        logic [WIDTH-1:0]                 period;
        logic [CHANNELS-1:0][WIDTH-1:0]   duty;
    } cfg_t;

    cfg_t             in_cfg, stg, nx;
    logic [WIDTH-1:0] cnt, period_sh;
    logic             pending, bnd, upd;

    assign in_cfg = {period, duty};
    // A load landing on the boundary cycle bypasses staging and applies immediately.
    assign nx     = load ? in_cfg : stg;
    assign upd    = bnd && (pending || load);
    assign busy   = pending;

`ifdef PWM_CENTER_EN
    logic dir_dn;

    // Short periods never count down, so the boundary falls back to cnt==0.
    assign bnd = (period_sh <= WIDTH'(1)) ? (cnt == '0) : (dir_dn && cnt == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            dir_dn <= 1'b0;
        end else if (bnd) begin
            dir_dn <= 1'b0;
            cnt    <= (cnt == '0 && (upd ? nx.period : period_sh) != '0) ? WIDTH'(1) : '0;
        end else if (!dir_dn && cnt < period_sh) begin
            cnt <= cnt + WIDTH'(1);
        end else begin
            cnt    <= cnt - WIDTH'(1);
            dir_dn <= 1'b1;
        end
    end
`else
    assign bnd = (cnt == period_sh);

    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (bnd) cnt <= '0;
        else          cnt <= cnt + WIDTH'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh   <= '1;
            stg         <= '0;
            pending     <= 1'b0;
            upd_ack     <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            upd_ack     <= upd;
            cycle_start <= (cnt == '0);
            if (load) stg <= in_cfg;
            if (upd) begin
                period_sh <= nx.period;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .upd     (upd),
            .duty_nx (nx.duty[i]),
            .cnt     (cnt),
            .out     (out[i])
        );
    end
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: vector table of period/duty configs scored per full period,
// plus hand sequences for mid-period loads, bypass, and reset abort.
module tb_pwm_multi;
    localparam int W  = 8;
    localparam int CH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load = 1'b0;
    logic [W-1:0]        period = '0;
    logic [CH-1:0][W-1:0] duty = '0;
    logic [CH-1:0]       out;
    logic                cycle_start, upd_ack, busy;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .period      (period),
        .duty        (duty),
        .load        (load),
        .out         (out),
        .cycle_start (cycle_start),
        .upd_ack     (upd_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ack_total = 0;

    always @(negedge clk) if (upd_ack) ack_total++;

    typedef struct {
        logic [W-1:0]          p;
        logic [CH-1:0][W-1:0]  d;
        int                    len;
        logic [CH-1:0][15:0]   hi;
    } vec_t;

    typedef struct {
        string                 name;
        int                    len;
        logic [CH-1:0][15:0]   hi;
    } exp_t;

    vec_t tbl[5];
    exp_t sb[$];
    exp_t e;
    int   m_len, m_busy;
    int   m_hi[CH];
    int   a0, h;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive_load(input logic [W-1:0] p, input logic [CH-1:0][W-1:0] d);
        period = p;
        duty   = d;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        while (!upd_ack && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!upd_ack) begin
            total++; bad++;
            $display("FAIL %s: upd_ack timeout got 0 want 1", nm);
        end
        @(negedge clk);
    endtask

    task automatic wait_cs(input string nm);
        int n = 0;
        while (!cycle_start && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!cycle_start) begin
            total++; bad++;
            $display("FAIL %s: cycle_start timeout got 0 want 1", nm);
        end
    endtask

    // One full period from a cycle_start sample up to the next one.
    task automatic measure(input string nm);
        wait_cs(nm);
        m_len  = 0;
        m_busy = 0;
        for (int c = 0; c < CH; c++) m_hi[c] = 0;
        do begin
            m_len++;
            if (busy) m_busy++;
            for (int c = 0; c < CH; c++) if (out[c]) m_hi[c]++;
            @(negedge clk);
        end while (!cycle_start && m_len < 1000);
    endtask

    initial begin
        tbl[0] = '{p: 8'd9,   d: {8'd255, 8'd10,  8'd3, 8'd0},   len: 10,  hi: {16'd10,  16'd10,  16'd3, 16'd0}};
        tbl[1] = '{p: 8'd4,   d: {8'd4,   8'd5,   8'd2, 8'd1},   len: 5,   hi: {16'd4,   16'd5,   16'd2, 16'd1}};
        tbl[2] = '{p: 8'd0,   d: {8'd200, 8'd0,   8'd1, 8'd0},   len: 1,   hi: {16'd1,   16'd0,   16'd1, 16'd0}};
        tbl[3] = '{p: 8'd255, d: {8'd1,   8'd0,   8'd255, 8'd128}, len: 256, hi: {16'd1, 16'd0,   16'd255, 16'd128}};
        tbl[4] = '{p: 8'd15,  d: {8'd7,   8'd8,   8'd15, 8'd16}, len: 16,  hi: {16'd7,   16'd8,   16'd15, 16'd16}};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out", int'(out), 0);
        chk("rst_cs", int'(cycle_start), 0);
        chk("rst_ack", int'(upd_ack), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_cs", int'(cycle_start), 1);
        chk("rel_out", int'(out), 0);

`ifdef PWM_CENTER_EN
        drive_load(8'd8, {8'd0, 8'd0, 8'd0, 8'd3});
        wait_ack("ctr3");
        measure("ctr3");
        chk("ctr3_len", m_len, 16);
        chk("ctr3_hi", m_hi[0], 5);
        a0 = ack_total;
        drive_load(8'd8, {8'd0, 8'd0, 8'd0, 8'd9});
        chk("ctr9_busy", int'(busy), 1);
        wait_ack("ctr9");
        measure("ctr9");
        chk("ctr9_len", m_len, 16);
        chk("ctr9_hi", m_hi[0], 16);
        chk("ctr9_acks", ack_total - a0, 1);
`else
        for (int i = 0; i < 5; i++) begin
            a0 = ack_total;
            drive_load(tbl[i].p, tbl[i].d);
            sb.push_back('{name: $sformatf("vec%0d", i), len: tbl[i].len, hi: tbl[i].hi});
            wait_ack($sformatf("vec%0d", i));
            measure($sformatf("vec%0d", i));
            e = sb.pop_front();
            chk({e.name, "_len"}, m_len, e.len);
            for (int c = 0; c < CH; c++)
                chk($sformatf("%s_hi%0d", e.name, c), m_hi[c], int'(e.hi[c]));
            chk({e.name, "_acks"}, ack_total - a0, 1);
        end

        // mid-period load: current period keeps old duty, busy until wrap
        drive_load(8'd99, {8'd0, 8'd0, 8'd0, 8'd50});
        wait_ack("b_setup");
        wait_cs("b");
        a0 = ack_total;
        h  = 0;
        for (int k = 0; k < 100; k++) begin
            if (out[0]) h++;
            if (k == 29) begin duty[0] = 8'd20; load = 1'b1; end
            if (k == 30) begin load = 1'b0; chk("b_busy_set", int'(busy), 1); end
            if (k == 98) chk("b_busy_hold", int'(busy), 1);
            if (k == 99) chk("b_ack", int'(upd_ack), 1);
            @(negedge clk);
        end
        chk("b_old_hi", h, 50);
        chk("b_cs", int'(cycle_start), 1);
        measure("b");
        chk("b_len", m_len, 100);
        chk("b_new_hi", m_hi[0], 20);
        chk("b_acks", ack_total - a0, 1);

        // two loads in one period: last one wins
        wait_cs("c");
        a0 = ack_total;
        h  = 0;
        for (int k = 0; k < 100; k++) begin
            if (out[0]) h++;
            if (k == 10) begin duty[0] = 8'd10; load = 1'b1; end
            if (k == 11) load = 1'b0;
            if (k == 40) begin duty[0] = 8'd70; load = 1'b1; end
            if (k == 41) load = 1'b0;
            @(negedge clk);
        end
        chk("c_old_hi", h, 20);
        measure("c");
        chk("c_new_hi", m_hi[0], 70);
        chk("c_acks", ack_total - a0, 1);

        // load on the boundary cycle: bypass, busy never set
        wait_cs("d");
        a0 = ack_total;
        h  = 0;
        for (int k = 0; k < 100; k++) begin
            if (out[0]) h++;
            if (k == 98) begin period = 8'd49; duty[0] = 8'd5; load = 1'b1; end
            if (k == 99) begin
                load = 1'b0;
                chk("d_busy", int'(busy), 0);
                chk("d_ack", int'(upd_ack), 1);
            end
            @(negedge clk);
        end
        chk("d_old_hi", h, 70);
        measure("d");
        chk("d_len", m_len, 50);
        chk("d_new_hi", m_hi[0], 5);
        chk("d_busy_win", m_busy, 0);
        chk("d_acks", ack_total - a0, 1);

        // reset mid-period with a pending load
        repeat (10) @(negedge clk);
        drive_load(8'd20, {8'd0, 8'd0, 8'd0, 8'd40});
        chk("e_busy_set", int'(busy), 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("e_out", int'(out), 0);
        chk("e_busy", int'(busy), 0);
        chk("e_ack", int'(upd_ack), 0);
        chk("e_cs", int'(cycle_start), 0);
        rst = 1'b0;
        a0  = ack_total;
        @(negedge clk);
        chk("e_cs_rel", int'(cycle_start), 1);
        measure("e");
        chk("e_len", m_len, 256);
        for (int c = 0; c < CH; c++) chk($sformatf("e_hi%0d", c), m_hi[c], 0);
        chk("e_busy_win", m_busy, 0);
        chk("e_acks", ack_total - a0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator: one shared period counter, per-channel duty compare, double-buffered (shadow) period/duty registers updated glitch-free only at period boundaries. Successor to the single-channel 8-bit pwm; drives LED/motor/servo outputs from a control register block. Adds programmable period, reset, channel count, atomic update handshake and cycle-start strobe.

Parameters:
WIDTH, 8, bit width of counter, period and each duty value
CHANNELS, 4, number of independent PWM outputs sharing one counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
period  input  WIDTH  period value P; period length P+1 clocks (edge mode)
duty  input  CHANNELS*WIDTH  packed duty values, channel i at bits [i*WIDTH +: WIDTH]
load  input  1  one-cycle strobe: stage period and duty for next boundary
out  output  CHANNELS  registered PWM outputs
cycle_start  output  1  one-cycle pulse, high in the cycle cnt==0
upd_ack  output  1  one-cycle pulse in the cycle after shadows are updated
busy  output  1  high while a staged load is pending (not yet applied)

Behaviour:
- Reset (rst=1 at clk edge): cnt=0, period_sh=all ones, duty_sh[*]=0, staging regs=0, pending=0; out=0, cycle_start=0, upd_ack=0, busy=0. Reset mid-period aborts the period; pending loads discarded.
- Counter (edge mode): cnt increments each clock; when cnt==period_sh, next cnt=0 (wrap). period_sh=0 -> cnt stays 0, every cycle is a boundary.
- load=1: period and duty copied into staging regs at that edge; pending=1. Further load while pending overwrites staging (last write wins); no error.
- Boundary (wrap cycle, cnt==period_sh): if pending, or load=1 in that same cycle (bypass: that cycle's inputs used directly), period_sh and duty_sh take staged values, pending=0, upd_ack=1 next cycle. Counter restarts at 0 regardless.
- busy = pending (registered).
- Compare: out[i] registered <= (cnt < duty_sh[i]); out lags cnt by one clock. High time per period = min(duty_sh[i], P+1) clocks. duty=0 -> constantly low; duty>P -> constantly high (100%), no glitch at wrap.
- Comparison unsigned, WIDTH bits; no overflow (counter never exceeds period_sh).
- cycle_start registered <= (cnt==0); with period_sh=0 it stays high continuously.
- New duty/period never take effect mid-period: no truncated or runt pulses.

Optional Feature:
PWM_CENTER_EN: when defined, counter is up/down (center-aligned): 0,1..P,P-1..1, repeat; period 2P clocks (P=0 holds cnt=0, out per compare rule). Direction flag reset to up. Boundary = the cycle cnt==1 while counting down (or cnt==0 when P<=1); shadow update, bypass, upd_ack rules identical. out[i] <= (cnt < duty_sh[i]); high time 2*duty-1 clocks for 1<=duty<=P, 2P for duty>P, pulse centred on cnt==0. Without macro: edge-aligned counter only, no direction flag synthesised.

Test Plan:
- Reset then load P=9, duty ch0..3={0,3,10,255} -> after first wrap, ch0 always 0, ch1 high 3 of 10 clocks, ch2 and ch3 always 1; upd_ack one pulse; cycle_start every 10 clocks.
- Running P=99, ch0=50; load ch0=20 at cnt=30 -> current period keeps 50 high clocks, busy=1 until wrap, next period 20 high; exactly one upd_ack.
- Two loads in one period (ch0=10 then ch0=70) -> only 70 applied at next boundary; one upd_ack.
- load asserted exactly when cnt==period_sh -> new values used from cnt=0 of next period (bypass), busy never observed high after edge.
- rst pulsed mid-period with load pending -> out=0, busy=0, cnt=0 next cycle; period_sh=255, duty_sh=0, no upd_ack.
- PWM_CENTER_EN, P=8, ch0=3 -> period 16 clocks, ch0 high 5 consecutive clocks centred on cnt==0; load ch0=9 -> ch0 high continuously from next boundary.
